// File: rtl/simf_wb_pkg.sv
// SIMF write-back queue shared types.
// Tag layout, FSM encoding and compare-mask helper.
package simf_wb_pkg;

  localparam int unsigned WB_LANES = 64;
  localparam int unsigned VADDR_W  = 10;
  localparam int unsigned SADDR_W  = 12;
  localparam int unsigned WFID_W   = 6;
  localparam int unsigned PC_W     = 32;

  typedef struct packed {
    logic                vgpr_en;
    logic                sgpr_en;
    logic                vcc_en;
    logic [VADDR_W-1:0]  vgpr_addr;
    logic [SADDR_W-1:0]  sgpr_addr;
    logic [WB_LANES-1:0] exec;
    logic [WFID_W-1:0]   wfid;
    logic [PC_W-1:0]     pc;
  } wb_tag_t;

  localparam int unsigned TAG_W = $bits(wb_tag_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } wb_state_e;

  function automatic logic [63:0] lane_mask64(
    input logic [WB_LANES-1:0] cmp,
    input logic [WB_LANES-1:0] exec
  );
    lane_mask64 = 64'(cmp & exec);
  endfunction

endpackage

// File: rtl/simf_wb_queue_fifo.sv
// In-order tag FIFO for the SIMF write-back stage.
// Push while full and pop while empty are ignored.
module simf_tag_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/simf_wb_queue.sv
// SIMF write-back stage: pairs FP completions with issued tags
// and drives one registered request per instruction to the arbiter.
module simf_wb_queue
  import simf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LANES = WB_LANES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_issue_valid,
  output logic                out_issue_ready,
  input  logic                in_vgpr_wr_en,
  input  logic                in_sgpr_wr_en,
  input  logic                in_vcc_wr_en,
  input  logic [9:0]          in_vgpr_dest_addr,
  input  logic [11:0]         in_sgpr_dest_addr,
  input  logic [LANES-1:0]    in_exec_mask,
  input  logic [5:0]          in_wfid,
  input  logic [31:0]         in_instr_pc,
  input  logic                in_fp_done,
  output logic                out_fp_ready,
  input  logic [LANES*32-1:0] in_fp_vdata,
  input  logic [LANES-1:0]    in_fp_cmp_mask,
  output logic                out_wb_valid,
  input  logic                in_wb_ready,
  output logic                out_vgpr_wr_en,
  output logic [9:0]          out_vgpr_dest_addr,
  output logic [LANES*32-1:0] out_vgpr_wr_data,
  output logic [LANES-1:0]    out_vgpr_wr_mask,
  output logic                out_sgpr_wr_en,
  output logic [11:0]         out_sgpr_dest_addr,
  output logic [63:0]         out_sgpr_wr_data,
  output logic                out_vcc_wr_en,
  output logic [63:0]         out_vcc_value,
  output logic                out_retire_valid,
  output logic [5:0]          out_retire_wfid,
  output logic [31:0]         out_retire_pc,
  output logic                out_err_orphan
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_state_e           state;
  wb_state_e           state_nxt;
  wb_tag_t             push_tag;
  wb_tag_t             head;
  logic [TAG_W-1:0]    head_bits;
  logic [AW:0]         fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pair;
  logic                hs;
  wb_tag_t             r_tag;
  logic [LANES*32-1:0] r_vdata;
  logic [63:0]         r_sdata;
  logic                err_q;

  // Unknown decoder enables collapse to 0 before they are stored
  always_comb begin
    push_tag           = '0;
    push_tag.vgpr_en   = (in_vgpr_wr_en === 1'b1);
    push_tag.sgpr_en   = (in_sgpr_wr_en === 1'b1);
    push_tag.vcc_en    = (in_vcc_wr_en === 1'b1);
    push_tag.vgpr_addr = in_vgpr_dest_addr;
    push_tag.sgpr_addr = in_sgpr_dest_addr;
    push_tag.exec      = WB_LANES'(in_exec_mask);
    push_tag.wfid      = in_wfid;
    push_tag.pc        = in_instr_pc;
  end

  simf_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_issue_valid),
    .wdata (push_tag),
    .pop   (pair),
    .rdata (head_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head            = wb_tag_t'(head_bits);
  assign out_issue_ready = ~fifo_full;
  assign out_fp_ready    = (state == ST_IDLE) |
                           ((state == ST_WB) & in_wb_ready);
  assign pair            = in_fp_done & out_fp_ready &
                           (fifo_count != '0);
  assign hs              = (state == ST_WB) & in_wb_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (pair) state_nxt = ST_WB;
      ST_WB:   if (in_wb_ready) state_nxt = pair ? ST_WB : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Output register only moves on a pair, so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_vdata <= '0;
      r_sdata <= '0;
    end else if (pair) begin
      r_tag   <= head;
      r_vdata <= in_fp_vdata;
      r_sdata <= lane_mask64(WB_LANES'(in_fp_cmp_mask), head.exec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        err_q <= 1'b0;
    else if (in_fp_done & fifo_empty)  err_q <= 1'b1;
  end

  assign out_wb_valid       = (state == ST_WB);
  assign out_vgpr_wr_en     = out_wb_valid & r_tag.vgpr_en;
  assign out_sgpr_wr_en     = out_wb_valid & r_tag.sgpr_en;
  assign out_vcc_wr_en      = out_wb_valid & r_tag.vcc_en;
  assign out_vgpr_dest_addr = r_tag.vgpr_addr;
  assign out_sgpr_dest_addr = r_tag.sgpr_addr;
  assign out_vgpr_wr_data   = r_vdata;
  assign out_vgpr_wr_mask   = LANES'(r_tag.exec);
  assign out_sgpr_wr_data   = r_sdata;
  assign out_vcc_value      = r_sdata;
  assign out_retire_valid   = hs;
  assign out_retire_wfid    = r_tag.wfid;
  assign out_retire_pc      = r_tag.pc;
  assign out_err_orphan     = err_q;

endmodule

// File: tb/tb_simf_wb_queue.sv
// Scoreboard bench for simf_wb_queue.
// Driver models the queue; a negedge monitor checks each request.
module tb_simf_wb_queue;

  localparam int DEPTH = 4;
  localparam int LANES = 64;
  localparam int VW    = LANES * 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_issue_valid;
  logic             out_issue_ready;
  logic             in_vgpr_wr_en;
  logic             in_sgpr_wr_en;
  logic             in_vcc_wr_en;
  logic [9:0]       in_vgpr_dest_addr;
  logic [11:0]      in_sgpr_dest_addr;
  logic [LANES-1:0] in_exec_mask;
  logic [5:0]       in_wfid;
  logic [31:0]      in_instr_pc;
  logic             in_fp_done;
  logic             out_fp_ready;
  logic [VW-1:0]    in_fp_vdata;
  logic [LANES-1:0] in_fp_cmp_mask;
  logic             out_wb_valid;
  logic             in_wb_ready;
  logic             out_vgpr_wr_en;
  logic [9:0]       out_vgpr_dest_addr;
  logic [VW-1:0]    out_vgpr_wr_data;
  logic [LANES-1:0] out_vgpr_wr_mask;
  logic             out_sgpr_wr_en;
  logic [11:0]      out_sgpr_dest_addr;
  logic [63:0]      out_sgpr_wr_data;
  logic             out_vcc_wr_en;
  logic [63:0]      out_vcc_value;
  logic             out_retire_valid;
  logic [5:0]       out_retire_wfid;
  logic [31:0]      out_retire_pc;
  logic             out_err_orphan;

  always #5 clk = ~clk;

  simf_wb_queue #(.DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_issue_valid     (in_issue_valid),
    .out_issue_ready    (out_issue_ready),
    .in_vgpr_wr_en      (in_vgpr_wr_en),
    .in_sgpr_wr_en      (in_sgpr_wr_en),
    .in_vcc_wr_en       (in_vcc_wr_en),
    .in_vgpr_dest_addr  (in_vgpr_dest_addr),
    .in_sgpr_dest_addr  (in_sgpr_dest_addr),
    .in_exec_mask       (in_exec_mask),
    .in_wfid            (in_wfid),
    .in_instr_pc        (in_instr_pc),
    .in_fp_done         (in_fp_done),
    .out_fp_ready       (out_fp_ready),
    .in_fp_vdata        (in_fp_vdata),
    .in_fp_cmp_mask     (in_fp_cmp_mask),
    .out_wb_valid       (out_wb_valid),
    .in_wb_ready        (in_wb_ready),
    .out_vgpr_wr_en     (out_vgpr_wr_en),
    .out_vgpr_dest_addr (out_vgpr_dest_addr),
    .out_vgpr_wr_data   (out_vgpr_wr_data),
    .out_vgpr_wr_mask   (out_vgpr_wr_mask),
    .out_sgpr_wr_en     (out_sgpr_wr_en),
    .out_sgpr_dest_addr (out_sgpr_dest_addr),
    .out_sgpr_wr_data   (out_sgpr_wr_data),
    .out_vcc_wr_en      (out_vcc_wr_en),
    .out_vcc_value      (out_vcc_value),
    .out_retire_valid   (out_retire_valid),
    .out_retire_wfid    (out_retire_wfid),
    .out_retire_pc      (out_retire_pc),
    .out_err_orphan     (out_err_orphan)
  );

  typedef struct {
    bit        v, s, c;
    bit [9:0]  va;
    bit [11:0] sa;
    bit [63:0] ex;
    bit [5:0]  wf;
    bit [31:0] pc;
  } tag_t;

  typedef struct {
    bit          v, s, c;
    bit [9:0]    va;
    bit [11:0]   sa;
    bit [VW-1:0] vd;
    bit [63:0]   vm;
    bit [63:0]   sd;
    bit [5:0]    wf;
    bit [31:0]   pc;
  } wb_t;

  tag_t tagq[$];
  wb_t  expq[$];
  wb_t  mon_e;
  bit   pend;
  bit   exp_err;
  int   checks;
  int   errors;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < LANES; i++) begin
        if (act[i*32+:32] !== exp[i*32+:32]) begin
          $display("FAIL %s lane %0d actual=%h required=%h t=%0t",
                   name, i, act[i*32+:32], exp[i*32+:32], $time);
          break;
        end
      end
    end
  endtask

  // Monitor: each presented request must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && out_wb_valid) begin
      if (expq.size() == 0) begin
        chk("spurious_wb", 1, 0);
      end else begin
        mon_e = expq[0];
        chk("vgpr_en",   out_vgpr_wr_en, mon_e.v);
        chk("sgpr_en",   out_sgpr_wr_en, mon_e.s);
        chk("vcc_en",    out_vcc_wr_en, mon_e.c);
        chk("vgpr_addr", out_vgpr_dest_addr, mon_e.va);
        chk("sgpr_addr", out_sgpr_dest_addr, mon_e.sa);
        chk_vec("vgpr_data", out_vgpr_wr_data, mon_e.vd);
        chk("vgpr_mask", out_vgpr_wr_mask, mon_e.vm);
        chk("sgpr_data", out_sgpr_wr_data, mon_e.sd);
        chk("vcc_value", out_vcc_value, mon_e.sd);
        chk("retire_wfid", out_retire_wfid, mon_e.wf);
        chk("retire_pc", out_retire_pc, mon_e.pc);
        chk("retire_pulse", out_retire_valid, in_wb_ready);
        if (in_wb_ready) void'(expq.pop_front());
      end
    end else if (rst_n) begin
      chk("retire_idle", out_retire_valid, 0);
    end
  end

  task automatic set_idle();
    in_issue_valid    = 0;
    in_vgpr_wr_en     = 0;
    in_sgpr_wr_en     = 0;
    in_vcc_wr_en      = 0;
    in_vgpr_dest_addr = '0;
    in_sgpr_dest_addr = '0;
    in_exec_mask      = '0;
    in_wfid           = '0;
    in_instr_pc       = '0;
    in_fp_done        = 0;
    in_fp_vdata       = '0;
    in_fp_cmp_mask    = '0;
    in_wb_ready       = 1;
  endtask

  task automatic rand_issue();
    in_issue_valid    = 1;
    in_vgpr_wr_en     = 1'($urandom);
    in_sgpr_wr_en     = 1'($urandom);
    in_vcc_wr_en      = 1'($urandom);
    in_vgpr_dest_addr = 10'($urandom);
    in_sgpr_dest_addr = 12'($urandom);
    in_exec_mask      = {$urandom, $urandom};
    in_wfid           = 6'($urandom);
    in_instr_pc       = $urandom;
  endtask

  task automatic rand_result();
    in_fp_done = 1;
    for (int i = 0; i < LANES; i++) in_fp_vdata[i*32+:32] = $urandom;
    in_fp_cmp_mask = {$urandom, $urandom};
  endtask

  // Inputs are set at posedge+1; this checks, advances the model, then waits one clock
  task automatic step();
    bit   pair;
    bit   push;
    int   sz;
    tag_t t;
    wb_t  w;
    #1;
    sz = tagq.size();
    chk("issue_ready", out_issue_ready, sz < DEPTH);
    chk("fp_ready", out_fp_ready, !pend || in_wb_ready);
    chk("wb_valid", out_wb_valid, pend);
    chk("err_orphan", out_err_orphan, exp_err);
    pair = in_fp_done && (!pend || in_wb_ready) && sz > 0;
    push = in_issue_valid && sz < DEPTH;
    if (in_fp_done && sz == 0) exp_err = 1;
    if (pend && in_wb_ready) pend = 0;
    if (pair) begin
      t    = tagq.pop_front();
      w.v  = t.v;
      w.s  = t.s;
      w.c  = t.c;
      w.va = t.va;
      w.sa = t.sa;
      w.vd = in_fp_vdata;
      w.vm = t.ex;
      w.sd = in_fp_cmp_mask & t.ex;
      w.wf = t.wf;
      w.pc = t.pc;
      expq.push_back(w);
      pend = 1;
    end
    if (push) begin
      t.v  = in_vgpr_wr_en;
      t.s  = in_sgpr_wr_en;
      t.c  = in_vcc_wr_en;
      t.va = in_vgpr_dest_addr;
      t.sa = in_sgpr_dest_addr;
      t.ex = in_exec_mask;
      t.wf = in_wfid;
      t.pc = in_instr_pc;
      tagq.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (tagq.size() > 0 || pend); i++) begin
      set_idle();
      in_fp_done = (tagq.size() > 0);
      step();
    end
    set_idle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    pend    = 0;
    exp_err = 0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_ready", out_issue_ready, 1);
    chk("rst_fp_ready", out_fp_ready, 1);
    chk("rst_wb_valid", out_wb_valid, 0);
    chk("rst_err", out_err_orphan, 0);
    chk("rst_retire", out_retire_valid, 0);
    chk("rst_sgpr_data", out_sgpr_wr_data, 0);
    rst_n = 1;

    // single VGPR op
    set_idle();
    in_issue_valid    = 1;
    in_vgpr_wr_en     = 1;
    in_vgpr_dest_addr = 10'h12;
    in_exec_mask      = '1;
    in_wfid           = 6'd5;
    in_instr_pc       = 32'h0000_0100;
    step();
    set_idle();
    in_fp_done = 1;
    for (int i = 0; i < LANES; i++) in_fp_vdata[i*32+:32] = 32'hA5A5_0000 | i;
    step();
    set_idle();
    chk("single_valid", out_wb_valid, 1);
    chk("single_vaddr", out_vgpr_dest_addr, 10'h12);
    chk("single_mask", out_vgpr_wr_mask, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("single_pc", out_retire_pc, 32'h100);
    step();

    // compare op to SGPR and VCC
    set_idle();
    in_issue_valid    = 1;
    in_sgpr_wr_en     = 1;
    in_vcc_wr_en      = 1;
    in_sgpr_dest_addr = 12'h0C0;
    in_exec_mask      = 64'h00FF;
    step();
    set_idle();
    in_fp_done     = 1;
    in_fp_cmp_mask = 64'h0F0F;
    step();
    set_idle();
    chk("cmp_sgpr_data", out_sgpr_wr_data, 64'h000F);
    chk("cmp_vcc_value", out_vcc_value, 64'h000F);
    chk("cmp_vgpr_en", out_vgpr_wr_en, 0);
    step();

    // backpressure
    for (int i = 0; i < 3; i++) begin
      set_idle();
      rand_issue();
      step();
    end
    set_idle();
    rand_result();
    step();
    for (int i = 0; i < 5; i++) begin
      set_idle();
      in_wb_ready = 0;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      set_idle();
      rand_result();
      step();
    end
    drain();

    // full FIFO; fifth push ignored, pop on full does not admit push
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_idle();
      rand_issue();
      step();
    end
    set_idle();
    rand_issue();
    rand_result();
    step();
    set_idle();
    step();
    drain();

    // orphan completion, then a normal op
    set_idle();
    rand_result();
    step();
    set_idle();
    step();
    set_idle();
    rand_issue();
    step();
    set_idle();
    rand_result();
    step();
    drain();

    // reset while a request is held
    for (int i = 0; i < 2; i++) begin
      set_idle();
      rand_issue();
      step();
    end
    set_idle();
    rand_result();
    step();
    set_idle();
    in_wb_ready = 0;
    step();
    rst_n = 0;
    tagq.delete();
    expq.delete();
    pend    = 0;
    exp_err = 0;
    #2;
    chk("rstop_wb_valid", out_wb_valid, 0);
    chk("rstop_issue_ready", out_issue_ready, 1);
    chk("rstop_err", out_err_orphan, 0);
    chk("rstop_retire", out_retire_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    set_idle();
    rand_result();
    step();
    set_idle();
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      set_idle();
      if ($urandom_range(1, 0) == 1) rand_issue();
      if ($urandom_range(4, 0) < 2) rand_result();
      in_wb_ready = ($urandom_range(9, 0) < 7);
      step();
    end
    drain();
    repeat (3) step();
    chk("drain_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
